// File: rtl/img_resize_line_reader_if.sv
// rtl/img_resize_line_reader_if.sv - valid/ready pixel stream bundle for the line reader output
interface img_resize_line_reader_if #(
  parameter int DATA_WIDTH = 24
);
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_valid;
  logic                  m_ready;
  logic                  m_last;

  modport master (
    output m_data,
    output m_valid,
    output m_last,
    input  m_ready
  );

  modport slave (
    input  m_data,
    input  m_valid,
    input  m_last,
    output m_ready
  );
endinterface

// File: rtl/img_resize_line_reader.sv
// rtl/img_resize_line_reader.sv - nearest-neighbour horizontal resampler reading a stored line from RAM port B
module img_resize_line_reader #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 24,
  parameter int FRAC_WIDTH = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                             b_clk,
  input  logic                             b_rst,
  input  logic                             line_start,
  input  logic [ADDR_WIDTH:0]              src_len,
  input  logic [ADDR_WIDTH:0]              out_len,
  input  logic [ADDR_WIDTH+FRAC_WIDTH-1:0] step,
  output logic [ADDR_WIDTH-1:0]            ram_addr,
  input  logic [DATA_WIDTH-1:0]            ram_rd_data,
  img_resize_line_reader_if.master         m,
  output logic                             busy,
  output logic                             line_done
);

  localparam int PW    = ADDR_WIDTH + 1 + FRAC_WIDTH;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CW    = PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_WIDTH:0]              src_len_q;
  logic [ADDR_WIDTH:0]              out_len_q;
  logic [ADDR_WIDTH+FRAC_WIDTH-1:0] step_q;
  logic [PW-1:0]                    pos_q;
  logic [ADDR_WIDTH:0]              issued_q;
  logic [ADDR_WIDTH-1:0]            ram_addr_q;

  // s1: address on ram_addr this cycle; s2: its data on ram_rd_data this cycle
  logic s1_valid_q, s1_last_q;
  logic s2_valid_q, s2_last_q;

  logic [DATA_WIDTH:0]  mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]        count_q;

  logic                 load, issue, issue_last;
  logic                 push, pop, fifo_valid;
  logic [CW:0]          occupancy;
  logic                 has_room;
  logic [PW:0]          pos_sum;
  logic [PW-1:0]        pos_next;
  logic [ADDR_WIDTH:0]  pos_int;
  logic [ADDR_WIDTH:0]  addr_clamped;

  assign fifo_valid = (count_q != '0);
  assign push       = s2_valid_q;
  assign pop        = fifo_valid & m.m_ready;

  // Reads already in the RAM pipeline count against FIFO space so no push can overflow
  assign occupancy  = {1'b0, count_q} + (CW+1)'(s1_valid_q) + (CW+1)'(s2_valid_q);
  assign has_room   = (occupancy < (CW+1)'(FIFO_DEPTH));

  // Accumulator saturates instead of wrapping; the clamp then pins it to the last pixel
  assign pos_sum      = {1'b0, pos_q} + {2'b00, step_q};
  assign pos_next     = pos_sum[PW] ? {PW{1'b1}} : pos_sum[PW-1:0];
  assign pos_int      = pos_q[PW-1:FRAC_WIDTH];
  assign addr_clamped = (pos_int >= src_len_q) ? (src_len_q - (ADDR_WIDTH+1)'(1)) : pos_int;

  assign ram_addr   = ram_addr_q;
  assign busy       = (state_q != S_IDLE);
  assign line_done  = (state_q == S_DONE);

  assign m.m_valid  = fifo_valid;
  assign m.m_data   = fifo_valid ? mem[rd_ptr_q][DATA_WIDTH-1:0] : '0;
  assign m.m_last   = fifo_valid ? mem[rd_ptr_q][DATA_WIDTH] : 1'b0;

  // Next-state and read-issue decisions
  always_comb begin
    state_d    = state_q;
    load       = 1'b0;
    issue      = 1'b0;
    issue_last = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (line_start) begin
          load = 1'b1;
          if (out_len == '0) begin
            state_d = S_DONE;
          end else begin
            issue      = 1'b1;
            issue_last = (out_len == (ADDR_WIDTH+1)'(1));
            state_d    = S_READ;
          end
        end
      end
      S_READ: begin
        if (issued_q == out_len_q) begin
          state_d = S_DRAIN;
        end else if (has_room) begin
          issue      = 1'b1;
          issue_last = (issued_q == (out_len_q - (ADDR_WIDTH+1)'(1)));
        end
      end
      S_DRAIN: begin
        if (!s1_valid_q && !s2_valid_q &&
            ((count_q == '0) || ((count_q == CW'(1)) && pop))) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge b_clk) begin
    if (b_rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Line parameters, position accumulator, RAM address and read pipeline flags
  always_ff @(posedge b_clk) begin
    if (b_rst) begin
      src_len_q  <= '0;
      out_len_q  <= '0;
      step_q     <= '0;
      pos_q      <= '0;
      issued_q   <= '0;
      ram_addr_q <= '0;
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_last_q  <= 1'b0;
    end else begin
      if (load) begin
        src_len_q <= src_len;
        out_len_q <= out_len;
        step_q    <= step;
        pos_q     <= '0;
        issued_q  <= '0;
      end
      if (issue) begin
        if (state_q == S_IDLE) begin
          ram_addr_q <= '0;
          pos_q      <= {1'b0, step};
          issued_q   <= (ADDR_WIDTH+1)'(1);
        end else begin
          ram_addr_q <= addr_clamped[ADDR_WIDTH-1:0];
          pos_q      <= pos_next;
          issued_q   <= issued_q + (ADDR_WIDTH+1)'(1);
        end
      end
      s1_valid_q <= issue;
      s1_last_q  <= issue_last;
      s2_valid_q <= s1_valid_q;
      s2_last_q  <= s1_last_q;
    end
  end

  // FIFO storage; contents need no reset since validity lives in count_q
  always_ff @(posedge b_clk) begin
    if (push) begin
      mem[wr_ptr_q] <= {s2_last_q, ram_rd_data};
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge b_clk) begin
    if (b_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule
